multi_input_trigger: RTL and testbench

Parametrised successor to the team's button-trigger front end. Synchronises `CHANNELS` raw push-button inputs and detects qualifying edges in a selectable mode. Each event produces a one-cycle increment pulse with a one-hot channel tag, a settle window, a refresh pulse, and a debounce block. Optional hold-to-repeat is included. It sits between the board inputs and the digit counters and display refresh logic.

---
 rtl/multi_input_trigger.sv | 168 ++++++++++++++++
 tb/tb_multi_input_trigger.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_input_trigger.sv
// Multi-channel push-button trigger: synchronises raw inputs, picks the lowest qualifying edge,
// and sequences increment pulse, settle window, refresh pulse and debounce block, with hold-to-repeat.
module multi_input_trigger #(
    parameter int CHANNELS        = 6,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int SETTLE_CYCLES   = 10,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trigger,
    input  logic [1:0]          edge_mode,
    output logic                inc_clk,
    output logic [CHANNELS-1:0] inc_sel,
    output logic                ref_clk,
    output logic                busy
);

    // state     | meaning
    // ST_ARM    | 3 cycles after reset, detection off so reset-time levels never count
    // ST_READY  | waiting for a candidate edge or a due repeat
    // ST_SETTLE | inc_clk issued, counting down to the ref_clk pulse
    // ST_BLOCK  | debounce window, edges discarded
    typedef enum logic [1:0] {ST_ARM, ST_READY, ST_SETTLE, ST_BLOCK} state_t;

    localparam int SW   = $clog2(SETTLE_CYCLES + 1);
    localparam int BW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam bit REP_EN = (REPEAT_DELAY > 0);

    state_t              r_state, w_state_nxt;
    logic [CHANNELS-1:0] r_meta, r_sync, r_prev;
    logic [1:0]          r_arm_cnt, w_arm_nxt;
    logic [SW-1:0]       r_settle_cnt, w_settle_nxt;
    logic [BW-1:0]       r_block_cnt, w_block_nxt;
    logic                r_hold_vld, w_hold_vld_nxt;
    logic [CHANNELS-1:0] r_hold_sel, w_hold_sel_nxt;
    logic [HW-1:0]       r_hold_cnt, w_hold_cnt_nxt;
    logic                r_inc_clk, w_inc_nxt;
    logic [CHANNELS-1:0] r_inc_sel, w_sel_nxt;
    logic                r_ref_clk, w_ref_nxt;

    logic [CHANNELS-1:0] w_cand, w_win;
    logic                w_found, w_hold_lvl, w_hold_ok, w_rep_due;

    always_comb begin
        case (edge_mode)
            2'b00:   w_cand = r_sync & ~r_prev;
            2'b01:   w_cand = ~r_sync & r_prev;
            2'b10:   w_cand = r_sync ^ r_prev;
            default: w_cand = '0;
        endcase
    end

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_cand[i] && !w_found) begin
                w_win[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    // Hold is live only in rising/falling mode while the held channel sits at its active level.
    assign w_hold_lvl = |(r_sync & r_hold_sel);
    assign w_hold_ok  = r_hold_vld && !edge_mode[1] && (edge_mode[0] ? !w_hold_lvl : w_hold_lvl);
    assign w_rep_due  = w_hold_ok && (r_hold_cnt == '0);

    always_comb begin
        w_state_nxt    = r_state;
        w_arm_nxt      = r_arm_cnt;
        w_settle_nxt   = r_settle_cnt;
        w_block_nxt    = r_block_cnt;
        w_inc_nxt      = 1'b0;
        w_sel_nxt      = '0;
        w_ref_nxt      = 1'b0;
        w_hold_vld_nxt = r_hold_vld;
        w_hold_sel_nxt = r_hold_sel;
        w_hold_cnt_nxt = r_hold_cnt;

        if (!w_hold_ok) begin
            w_hold_vld_nxt = 1'b0;
            w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt != '0) begin
            w_hold_cnt_nxt = r_hold_cnt - 1'b1;
        end

        case (r_state)
            ST_ARM: begin
                if (r_arm_cnt == 2'd0) w_state_nxt = ST_READY;
                else                   w_arm_nxt   = r_arm_cnt - 2'd1;
            end
            ST_READY: begin
                if (w_found) begin
                    w_state_nxt    = ST_SETTLE;
                    w_settle_nxt   = SW'(SETTLE_CYCLES);
                    w_inc_nxt      = 1'b1;
                    w_sel_nxt      = w_win;
                    w_hold_sel_nxt = w_win;
                    w_hold_vld_nxt = REP_EN && !edge_mode[1];
                    w_hold_cnt_nxt = HW'(REPEAT_DELAY - 1);
                end else if (w_rep_due) begin
                    w_state_nxt    = ST_SETTLE;
                    w_settle_nxt   = SW'(SETTLE_CYCLES);
                    w_inc_nxt      = 1'b1;
                    w_sel_nxt      = r_hold_sel;
                    w_hold_cnt_nxt = HW'(REPEAT_RATE - 1);
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = ST_BLOCK;
                    w_block_nxt = BW'(DEBOUNCE_CYCLES - 1);
                end else begin
                    w_settle_nxt = r_settle_cnt - 1'b1;
                    w_ref_nxt    = (r_settle_cnt == SW'(1));
                end
            end
            ST_BLOCK: begin
                if (r_block_cnt == '0) w_state_nxt = ST_READY;
                else                   w_block_nxt = r_block_cnt - 1'b1;
            end
            default: w_state_nxt = ST_ARM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta       <= '0;
            r_sync       <= '0;
            r_prev       <= '0;
            r_state      <= ST_ARM;
            r_arm_cnt    <= 2'd2;
            r_settle_cnt <= '0;
            r_block_cnt  <= '0;
            r_hold_vld   <= 1'b0;
            r_hold_sel   <= '0;
            r_hold_cnt   <= '0;
            r_inc_clk    <= 1'b0;
            r_inc_sel    <= '0;
            r_ref_clk    <= 1'b0;
        end else begin
            r_meta       <= trigger;
            r_sync       <= r_meta;
            r_prev       <= r_sync;
            r_state      <= w_state_nxt;
            r_arm_cnt    <= w_arm_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_block_cnt  <= w_block_nxt;
            r_hold_vld   <= w_hold_vld_nxt;
            r_hold_sel   <= w_hold_sel_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_inc_clk    <= w_inc_nxt;
            r_inc_sel    <= w_sel_nxt;
            r_ref_clk    <= w_ref_nxt;
        end
    end

    assign inc_clk = r_inc_clk;
    assign inc_sel = r_inc_sel;
    assign ref_clk = r_ref_clk;
    assign busy    = (r_state != ST_READY);

endmodule

// File: tb/tb_multi_input_trigger.sv
// Directed bench for multi_input_trigger: event timing, channel priority, modes, hold-repeat and reset abort.
`timescale 1ns/1ps
module tb_multi_input_trigger;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] trigger;
    logic [1:0] edge_mode;
    logic       inc_clk;
    logic [5:0] inc_sel;
    logic       ref_clk;
    logic       busy;

    multi_input_trigger #(
        .CHANNELS(6), .DEBOUNCE_CYCLES(20), .SETTLE_CYCLES(4),
        .REPEAT_DELAY(100), .REPEAT_RATE(40)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .edge_mode(edge_mode),
        .inc_clk(inc_clk), .inc_sel(inc_sel), .ref_clk(ref_clk), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         inc_t[$];
    logic [5:0] inc_s[$];
    int         ref_t[$];
    int         overlap = 0;

    always @(negedge clk) begin
        if (inc_clk) begin
            inc_t.push_back(cyc);
            inc_s.push_back(inc_sel);
        end
        if (ref_clk) ref_t.push_back(cyc);
        if (inc_clk && ref_clk) overlap++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        inc_t.delete();
        inc_s.delete();
        ref_t.delete();
    endtask

    task automatic drive(input logic [5:0] tv, output int n);
        @(posedge clk);
        #1;
        trigger = tv;
        n = cyc;
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(posedge clk);
        #1;
        edge_mode = m;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    int n, t, t2, r, dummy;
    int offs[5] = '{0, 100, 140, 180, 220};

    initial begin
        reset     = 1'b1;
        trigger   = 6'b000001;
        edge_mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inc", inc_clk, 1'b0);
        check("rst_sel", inc_sel, 6'b0);
        check("rst_ref", ref_clk, 1'b0);
        check("rst_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        r = cyc;
        wait_to(r + 2);
        check("arm_busy", busy, 1'b1);
        wait_to(r + 3);
        check("arm_done", busy, 1'b0);
        wait_to(r + 12);
        check("arm_no_evt", inc_t.size(), 0);

        // single rising edge on channel 3
        clr();
        drive(6'b001001, n);
        t = n + 3;
        wait_to(t - 1);
        check("lat_early", inc_clk, 1'b0);
        wait_to(t);
        check("lat_inc", inc_clk, 1'b1);
        check("lat_sel", inc_sel, 6'b001000);
        check("lat_busy", busy, 1'b1);
        wait_to(t + 1);
        check("inc_1cyc", inc_clk, 1'b0);
        check("sel_clr", inc_sel, 6'b0);
        wait_to(t + 3);
        check("ref_early", ref_clk, 1'b0);
        wait_to(t + 4);
        check("ref_pulse", ref_clk, 1'b1);
        drive(6'b000001, dummy);
        check("ref_1cyc", ref_clk, 1'b0);
        wait_to(t + 24);
        check("blk_busy", busy, 1'b1);
        wait_to(t + 25);
        check("ready_busy", busy, 1'b0);
        wait_to(t + 40);
        check("ch3_inc_cnt", inc_t.size(), 1);
        check("ch3_ref_cnt", ref_t.size(), 1);

        // simultaneous rise on channels 1 and 4, bounce on 2 during block
        clr();
        drive(6'b010011, n);
        t = n + 3;
        wait_to(t);
        check("prio_sel", inc_sel, 6'b000010);
        wait_to(t + 9);
        drive(6'b000101, dummy);
        wait_to(t + 11);
        drive(6'b000001, dummy);
        wait_to(t + 50);
        check("prio_cnt", inc_t.size(), 1);

        // falling, both, disabled
        clr();
        set_mode(2'b01);
        drive(6'b000000, n);
        t = n + 3;
        wait_to(t);
        check("fall_inc", inc_clk, 1'b1);
        check("fall_sel", inc_sel, 6'b000001);
        wait_to(t + 29);
        set_mode(2'b10);
        wait_to(t + 34);
        drive(6'b000001, n);
        t2 = n + 3;
        wait_to(t2);
        check("both_inc", inc_clk, 1'b1);
        check("both_sel", inc_sel, 6'b000001);
        wait_to(t2 + 29);
        set_mode(2'b11);
        drive(6'b000000, dummy);
        wait_to(dummy + 4);
        drive(6'b000010, dummy);
        wait_to(dummy + 4);
        drive(6'b000000, dummy);
        wait_to(dummy + 40);
        check("mode_cnt", inc_t.size(), 2);
        set_mode(2'b00);

        // hold channel 5 for 250 clocks
        clr();
        drive(6'b100000, n);
        t = n + 3;
        wait_to(n + 249);
        drive(6'b000000, dummy);
        wait_to(n + 320);
        check("hold_cnt", inc_t.size(), 5);
        check("hold_ref_cnt", ref_t.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_t%0d", i), (i < inc_t.size()) ? inc_t[i] : -1, t + offs[i]);
            check($sformatf("hold_s%0d", i), (i < inc_s.size()) ? inc_s[i] : 6'b0, 6'b100000);
            check($sformatf("hold_r%0d", i), (i < ref_t.size()) ? ref_t[i] : -1, t + offs[i] + 4);
        end

        // reset during settle
        clr();
        drive(6'b000100, n);
        t = n + 3;
        wait_to(t);
        check("abort_inc", inc_clk, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_inc0", inc_clk, 1'b0);
        check("abort_sel0", inc_sel, 6'b0);
        check("abort_ref0", ref_clk, 1'b0);
        check("abort_busy", busy, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        r = cyc;
        wait_to(r + 10);
        check("abort_no_ref", ref_t.size(), 0);
        check("abort_inc_cnt", inc_t.size(), 1);
        drive(6'b010100, n);
        wait_to(n + 3);
        check("rearm_inc", inc_clk, 1'b1);
        check("rearm_sel", inc_sel, 6'b010000);
        wait_to(n + 7);
        check("rearm_ref", ref_clk, 1'b1);

        check("no_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
